// File: rtl/sseg_scan_mux.sv
// Four-digit multiplexed seven-segment driver with frame-synchronous, tear-free pattern updates.
// Captured data waits in a pending set and is promoted to the active set only at a frame wrap.
module sseg_scan_mux #(
  parameter int unsigned N = 18
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic [7:0] in3,
  input  logic [3:0] blank,
  output logic [3:0] an,
  output logic [7:0] sseg,
  output logic       frame_start,
  output logic       pending
);

  logic [N-1:0]    q_q, q_d;
  logic [3:0][7:0] act_pat_q, act_pat_d;
  logic [3:0]      act_blank_q, act_blank_d;
  logic [3:0][7:0] pend_pat_q, pend_pat_d;
  logic [3:0]      pend_blank_q, pend_blank_d;
  logic            pending_q, pending_d;
  logic [3:0]      an_q, an_d;
  logic [7:0]      sseg_q, sseg_d;
  logic            frame_start_q, frame_start_d;

  logic [3:0][7:0] live_pat;
  logic            wrap;
  logic [1:0]      sel;
  logic [3:0]      onehot;

  assign live_pat = {in3, in2, in1, in0};
  assign wrap     = (q_q == {N{1'b1}});
  assign sel      = q_q[N-1 -: 2];

  always_comb begin
    q_d           = q_q + 1'b1;
    frame_start_d = wrap;
    act_pat_d     = act_pat_q;
    act_blank_d   = act_blank_q;
    pend_pat_d    = pend_pat_q;
    pend_blank_d  = pend_blank_q;
    pending_d     = pending_q;

    if (load) begin
      if (wrap) begin
        // A load on the wrap edge bypasses and discards anything pending.
        act_pat_d   = live_pat;
        act_blank_d = blank;
        pending_d   = 1'b0;
      end else begin
        pend_pat_d   = live_pat;
        pend_blank_d = blank;
        pending_d    = 1'b1;
      end
    end else if (wrap && pending_q) begin
      act_pat_d   = pend_pat_q;
      act_blank_d = pend_blank_q;
      pending_d   = 1'b0;
    end
  end

  // Output stage uses act_*_q: the wrap edge has already promoted the new set
  // by the time slot 0 of the next frame is registered.
  always_comb begin
    onehot = 4'b0001 << sel;
    if (act_blank_q[sel]) begin
      an_d   = 4'b1111;
      sseg_d = 8'hFF;
    end else begin
      an_d   = ~onehot;
      sseg_d = act_pat_q[sel];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q           <= '0;
      act_pat_q     <= {4{8'hFF}};
      act_blank_q   <= 4'b1111;
      pend_pat_q    <= {4{8'hFF}};
      pend_blank_q  <= 4'b1111;
      pending_q     <= 1'b0;
      an_q          <= 4'b1111;
      sseg_q        <= 8'hFF;
      frame_start_q <= 1'b0;
    end else begin
      q_q           <= q_d;
      act_pat_q     <= act_pat_d;
      act_blank_q   <= act_blank_d;
      pend_pat_q    <= pend_pat_d;
      pend_blank_q  <= pend_blank_d;
      pending_q     <= pending_d;
      an_q          <= an_d;
      sseg_q        <= sseg_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign an          = an_q;
  assign sseg        = sseg_q;
  assign frame_start = frame_start_q;
  assign pending     = pending_q;

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Directed bench for sseg_scan_mux with N=4 (4-cycle dwell, 16-cycle frame).
module tb_sseg_scan_mux;

  typedef struct {
    logic [3:0] an;
    logic [7:0] sseg;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       load = 1'b0;
  logic [7:0] in0 = 8'hFF, in1 = 8'hFF, in2 = 8'hFF, in3 = 8'hFF;
  logic [3:0] blank = 4'b1111;
  logic [3:0] an;
  logic [7:0] sseg;
  logic       frame_start, pending;

  int   n_vec = 0;
  int   n_err = 0;
  int   t = 0;
  logic watch99 = 1'b0;
  vec_t tbl [16];

  sseg_scan_mux #(.N(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (load),
    .in0         (in0),
    .in1         (in1),
    .in2         (in2),
    .in3         (in3),
    .blank       (blank),
    .an          (an),
    .sseg        (sseg),
    .frame_start (frame_start),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d got %h want %h", nm, t, got, exp);
    end
  endtask

  // Stale pattern 99 must never reach the segments.
  always @(negedge clk) begin
    if (watch99) begin
      n_vec++;
      if (sseg === 8'h99) begin
        n_err++;
        $display("FAIL no_99 t=%0d got %h want not 99", t, sseg);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    t++;
    @(negedge clk);
  endtask

  task automatic goto_q(input int v);
    while ((t % 16) != v) step();
  endtask

  task automatic set_tbl(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                         input logic [7:0] p3, input logic [3:0] bl);
    logic [3:0][7:0] pp;
    logic [3:0]      a;
    pp = {p3, p2, p1, p0};
    for (int i = 0; i < 16; i++) begin
      if (bl[i/4]) begin
        tbl[i].an   = 4'b1111;
        tbl[i].sseg = 8'hFF;
      end else begin
        a           = 4'b0001 << (i / 4);
        tbl[i].an   = ~a;
        tbl[i].sseg = pp[i/4];
      end
    end
  endtask

  // Expects to start at q==0 of a fresh frame; compares the 16 slots of that frame.
  task automatic check_frame(input string nm);
    goto_q(0);
    chk({nm, "_fs"}, {7'd0, frame_start}, 8'd1);
    chk({nm, "_pend"}, {7'd0, pending}, 8'd0);
    for (int i = 0; i < 16; i++) begin
      step();
      chk({nm, "_an"}, {4'd0, an}, {4'd0, tbl[i].an});
      chk({nm, "_sseg"}, sseg, tbl[i].sseg);
    end
  endtask

  initial begin
    // Reset held 3 cycles
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_an", {4'd0, an}, 8'h0F);
      chk("rst_sseg", sseg, 8'hFF);
      chk("rst_pend", {7'd0, pending}, 8'd0);
      chk("rst_fs", {7'd0, frame_start}, 8'd0);
    end
    reset_n = 1'b1;
    t = 0;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("blank_an", {4'd0, an}, 8'h0F);
      chk("blank_sseg", sseg, 8'hFF);
      chk("blank_pend", {7'd0, pending}, 8'd0);
      chk("first_fs", {7'd0, frame_start}, (k == 16) ? 8'd1 : 8'd0);
    end

    // Normal load at q=5
    goto_q(5);
    in0 = 8'hC0; in1 = 8'hF9; in2 = 8'hA4; in3 = 8'hB0; blank = 4'b0000; load = 1'b1;
    step();
    load = 1'b0;
    chk("norm_pend", {7'd0, pending}, 8'd1);
    set_tbl(8'hC0, 8'hF9, 8'hA4, 8'hB0, 4'b0000);
    check_frame("norm");

    // Last load within a frame wins
    watch99 = 1'b1;
    goto_q(3);
    in0 = 8'h99; load = 1'b1;
    step();
    load = 1'b0;
    goto_q(9);
    in0 = 8'h92; load = 1'b1;
    step();
    load = 1'b0;
    set_tbl(8'h92, 8'hF9, 8'hA4, 8'hB0, 4'b0000);
    check_frame("last");
    watch99 = 1'b0;

    // Load on the wrap edge goes straight to active
    goto_q(15);
    in0 = 8'hF8; load = 1'b1;
    step();
    load = 1'b0;
    chk("wrap_pend", {7'd0, pending}, 8'd0);
    set_tbl(8'hF8, 8'hF9, 8'hA4, 8'hB0, 4'b0000);
    check_frame("wrap");

    // Blanking digits 1 and 3
    goto_q(2);
    blank = 4'b1010; load = 1'b1;
    step();
    load = 1'b0;
    set_tbl(8'hF8, 8'hF9, 8'hA4, 8'hB0, 4'b1010);
    check_frame("blank");

    // Mid-frame reset discards pending data
    goto_q(6);
    in0 = 8'h86; blank = 4'b0000; load = 1'b1;
    step();
    load = 1'b0;
    chk("mid_pend_q7", {7'd0, pending}, 8'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_an", {4'd0, an}, 8'h0F);
    chk("mid_sseg", sseg, 8'hFF);
    chk("mid_pend", {7'd0, pending}, 8'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    t = 0;
    step();
    set_tbl(8'hFF, 8'hFF, 8'hFF, 8'hFF, 4'b1111);
    check_frame("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout t=%0d got running want finished", t);
    $fatal(1);
  end

endmodule

// File: doc/sseg_scan_mux.md
SSEG_SCAN_MUX -- requirements
Module: sseg_scan_mux

Interface
REQ-001 The block SHALL have parameter N, default 18, meaning refresh counter width, with N>=3, digit dwell 2^(N-2) clk cycles and frame length 2^N cycles.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port load, input, 1 bit: capture strobe for in0..in3 and blank.
REQ-005 The block SHALL have ports in0, in1, in2, in3, input, 8 bits each: active-low segment patterns {dp,g,f,e,d,c,b,a} for digits 0..3.
REQ-006 The block SHALL have port blank, input, 4 bits: per-digit blank mask, 1 = digit off.
REQ-007 The block SHALL have port an, output, 4 bits: active-low anode enables, bit i = digit i.
REQ-008 The block SHALL have port sseg, output, 8 bits: active-low segments, same bit order as in0..in3.
REQ-009 The block SHALL have port frame_start, output, 1 bit: one-cycle pulse at the start of each frame.
REQ-010 The block SHALL have port pending, output, 1 bit: high when captured data is waiting for the next frame boundary.

Function
REQ-011 Counter q (N bits) SHALL increment every cycle and wrap from 2^N-1 to 0.
REQ-012 Digit select SHALL be sel = q[N-1:N-2]: 0 -> digit 0 ... 3 -> digit 3.
REQ-013 an/sseg SHALL be registered: in the cycle after q holds value v, an/sseg reflect sel(v), giving 1-cycle latency.
REQ-014 For a non-blanked selected digit i, an SHALL have only bit i low, and sseg SHALL equal active pattern i.
REQ-015 For a blanked selected digit, an SHALL be 4'b1111 and sseg SHALL be 8'hFF.
REQ-016 The display SHALL use only the active set (four patterns plus blank mask); live inputs SHALL never drive sseg directly.
REQ-017 load=1 at an edge where q != 2^N-1 SHALL copy in0..in3/blank into the pending set and set pending=1 at that edge.
REQ-018 Several loads within one frame: the last SHALL win; earlier captured values SHALL never reach the display.
REQ-019 At the edge where q == 2^N-1 with pending=1 and load=0, active SHALL be loaded from the pending set and pending SHALL clear.
REQ-020 At the edge where q == 2^N-1 with load=1, active SHALL be loaded directly from the live inputs; any pending set SHALL be discarded and pending SHALL be 0.
REQ-021 At the edge where q == 2^N-1 with pending=0 and load=0, active SHALL be unchanged.
REQ-022 frame_start SHALL be registered and set for exactly the cycle in which q == 0 following a wrap.
REQ-023 The first displayed slot of a frame, digit 0 with q == 0 registered one cycle later, SHALL already use the newly transferred active set, so frames never tear.

Reset
REQ-024 reset_n low SHALL immediately set q=0, an=4'b1111, sseg=8'hFF, frame_start=0, pending=0, active patterns=8'hFF, active blank=4'b1111, and pending set=8'hFF/4'b1111.
REQ-025 Reset asserted mid-frame SHALL discard pending data; after release, q SHALL restart at 0 and the first frame_start SHALL occur 2^N cycles after release.
REQ-026 Until the first load is transferred, the display SHALL stay fully blank: an=1111, sseg=FF.

Verification (N=4: dwell 4 cycles, frame 16 cycles)
REQ-027 Reset: hold reset_n low 3 cycles, then release -> an=1111, sseg=FF, pending=0, frame_start=0 throughout, and the first frame_start 16 cycles after release.
REQ-028 Normal load: load in0=C0, in1=F9, in2=A4, in3=B0, blank=0000 at q=5 -> pending=1 from the next cycle; on wrap pending=0 and frame_start=1, then an=1110 x4/C0, 1101 x4/F9, 1011 x4/A4, 0111 x4/B0.
REQ-029 Last-wins: load in0=99 at q=3, then in0=92 at q=9 -> digit 0 shows 92 after the boundary; 99 never appears on sseg.
REQ-030 Load on wrap: load in0=F8 at q=15 -> pending never asserts; digit 0 shows F8 in the frame starting at the next frame_start.
REQ-031 Blanking: active blank=1010 -> slots 1 and 3 give an=1111, sseg=FF; slots 0 and 2 show their patterns normally.
REQ-032 Mid-frame reset: pending=1 at q=7, pulse reset_n low -> an=1111, sseg=FF, pending=0 immediately; the old pending data is never displayed after release.
